// File: rtl/decode_fetch_buffer.sv
// Multi-lane fetch buffer in front of decode. Accepts up to LANES instructions
// per cycle into a circular buffer, assigns per-instruction addresses and major
// IDs, and hands one instruction per cycle to the decoder through a registered
// output stage that honours stall backpressure.
// Optional feature macro: DECODE_BUF_BYPASS_EN (lane 0 of a push into an empty
// buffer goes straight to the output stage, one-edge latency).
module decode_fetch_buffer #(
    parameter int ADDR_W  = 64,
    parameter int INST_W  = 32,
    parameter int PID_W   = 20,
    parameter int TID_W   = 16,
    parameter int MAJID_W = 64,
    parameter int LANES   = 4,
    parameter int DEPTH   = 16
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     flush_i,
    input  logic                     enable_i,
    input  logic [LANES-1:0]         laneValid_i,
    input  logic [LANES*INST_W-1:0]  packet_i,
    input  logic [ADDR_W-1:0]        packetAddr_i,
    input  logic                     is64Bit_i,
    input  logic [PID_W-1:0]         pid_i,
    input  logic [TID_W-1:0]         tid_i,
    output logic                     ready_o,
    output logic                     overflow_o,
    input  logic                     stall_i,
    output logic                     enable_o,
    output logic [INST_W-1:0]        instruction_o,
    output logic [ADDR_W-1:0]        instructionAddress_o,
    output logic                     is64Bit_o,
    output logic [PID_W-1:0]         pid_o,
    output logic [TID_W-1:0]         tid_o,
    output logic [MAJID_W-1:0]       instructionMajId_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [INST_W-1:0]  inst;
        logic [ADDR_W-1:0]  addr;
        logic               is64;
        logic [PID_W-1:0]   pid;
        logic [TID_W-1:0]   tid;
        logic [MAJID_W-1:0] majid;
    } entry_t;

    entry_t             mem [DEPTH];
    entry_t             lane_entry [LANES];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [MAJID_W-1:0] majid_reg;
    logic [CNT_W-1:0]   lane_cnt;
    logic [CNT_W-1:0]   skip;
    logic [CNT_W-1:0]   buffered;
    logic               push;
    logic               pop;
    logic               bypass;

    // Per-lane entry as it would be stored: lane 0 sits in the top INST_W bits.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_entry[gi] = '{
                inst:  packet_i[(LANES-1-gi)*INST_W +: INST_W],
                addr:  packetAddr_i + (ADDR_W'(gi) << 2),
                is64:  is64Bit_i,
                pid:   pid_i,
                tid:   tid_i,
                majid: majid_reg + MAJID_W'(gi)
            };
        end
    endgenerate

    // Accepted lanes: run of consecutive valid bits starting at lane 0.
    always_comb begin
        logic run;
        lane_cnt = '0;
        run      = 1'b1;
        for (int j = 0; j < LANES; j++) begin
            if (run && laneValid_i[j]) begin
                lane_cnt = lane_cnt + CNT_W'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

    assign ready_o = (count_reg <= CNT_W'(DEPTH - LANES));
    assign push    = enable_i && ready_o && !flush_i && (lane_cnt != '0);
    assign pop     = !flush_i && !stall_i && (count_reg != '0);

`ifdef DECODE_BUF_BYPASS_EN
    // Output stage never holds when unstalled, so empty buffer + no stall is enough.
    assign bypass = push && !stall_i && (count_reg == '0);
`else
    assign bypass = 1'b0;
`endif

    assign skip     = CNT_W'(bypass);
    assign buffered = push ? (lane_cnt - skip) : '0;
    assign count_o  = count_reg;

    // Buffer write: accepted lanes (minus a bypassed lane 0) go to consecutive slots.
    always_ff @(posedge clock_i) begin
        for (int j = 0; j < LANES; j++) begin
            if (push && (CNT_W'(j) < lane_cnt) && (CNT_W'(j) >= skip)) begin
                mem[wr_ptr_reg + PTR_W'(j) - PTR_W'(skip)] <= lane_entry[j];
            end
        end
    end

    // Pointers, occupancy, major-ID counter and overflow pulse.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            majid_reg  <= '0;
            overflow_o <= 1'b0;
        end else begin
            overflow_o <= enable_i && !ready_o && !flush_i;
            if (flush_i) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                wr_ptr_reg <= wr_ptr_reg + buffered[PTR_W-1:0];
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(pop);
                count_reg  <= count_reg + buffered - CNT_W'(pop);
            end
            // IDs keep counting across flushes so they stay unique.
            if (push) begin
                majid_reg <= majid_reg + MAJID_W'(lane_cnt);
            end
        end
    end

    // Registered output stage: holds on stall, loads head (or bypassed lane 0).
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            enable_o             <= 1'b0;
            instruction_o        <= '0;
            instructionAddress_o <= '0;
            is64Bit_o            <= 1'b0;
            pid_o                <= '0;
            tid_o                <= '0;
            instructionMajId_o   <= '0;
        end else if (flush_i) begin
            enable_o <= 1'b0;
        end else if (!stall_i) begin
            if (pop || bypass) begin
                enable_o             <= 1'b1;
                instruction_o        <= pop ? mem[rd_ptr_reg].inst  : lane_entry[0].inst;
                instructionAddress_o <= pop ? mem[rd_ptr_reg].addr  : lane_entry[0].addr;
                is64Bit_o            <= pop ? mem[rd_ptr_reg].is64  : lane_entry[0].is64;
                pid_o                <= pop ? mem[rd_ptr_reg].pid   : lane_entry[0].pid;
                tid_o                <= pop ? mem[rd_ptr_reg].tid   : lane_entry[0].tid;
                instructionMajId_o   <= pop ? mem[rd_ptr_reg].majid : lane_entry[0].majid;
            end else begin
                enable_o <= 1'b0;
            end
        end
    end

endmodule
